// File: rtl/writeback_ctrl.sv
// Writeback controller: selects register-file write data per opcode, issues and waits for load reads.
// Non-loads retire one cycle after acceptance; loads retire one cycle after mem_rvalid or abort on timeout.
module writeback_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instruction,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] WriteData,
  output logic        Write,
  output logic [4:0]  wb_rd,
  output logic        done,
  output logic        err
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_ILOAD  = 7'b0000011;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, WRITE} state_t;

  state_t        r_state, w_next_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_mem_addr;
  logic [4:0]    r_ld_rd;
  logic [2:0]    r_ld_f3;
  logic [1:0]    r_ld_off;
  logic [31:0]   r_wdata;
  logic [4:0]    r_rd;
  logic          r_write, r_done, r_err;

  logic [6:0]  w_op;
  logic [4:0]  w_rd_in;
  logic [2:0]  w_f3_in;
  logic        w_fire, w_wr, w_err, w_load_go;
  logic [31:0] w_wdata;
  logic [4:0]  w_rd;

  assign w_op    = instruction[6:0];
  assign w_rd_in = instruction[11:7];
  assign w_f3_in = instruction[14:12];

  function automatic logic [31:0] load_extract(input logic [31:0] data, input logic [2:0] f3,
                                                input logic [1:0] off);
    logic [31:0] sh;
    sh = data >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return data;
    endcase
  endfunction

  // Unknown funct3 values are handled as LW, so they carry word alignment too.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return off[0];
      default:        return off != 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_fire       = 1'b0;
    w_wr         = 1'b0;
    w_err        = 1'b0;
    w_load_go    = 1'b0;
    w_wdata      = r_wdata;
    w_rd         = r_rd;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_rd = w_rd_in;
          if (w_op == OP_ILOAD && !misaligned(w_f3_in, alu_result[1:0])) begin
            w_next_state = MEM_WAIT;
            w_load_go    = 1'b1;
          end else begin
            w_next_state = WRITE;
            w_fire       = 1'b1;
            case (w_op)
              OP_RTYPE, OP_IARITH: begin w_wdata = alu_result; w_wr = 1'b1; end
              OP_JAL, OP_JALR:     begin w_wdata = pc + 32'd4; w_wr = 1'b1; end
              OP_LUI:              begin w_wdata = imm;        w_wr = 1'b1; end
              OP_AUIPC:            begin w_wdata = pc + imm;   w_wr = 1'b1; end
              OP_ILOAD:            w_err = 1'b1;
              default:             ;
            endcase
            if (w_rd_in == 5'd0) w_wr = 1'b0;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_rvalid) begin
          w_next_state = WRITE;
          w_fire       = 1'b1;
          w_wdata      = load_extract(mem_rdata, r_ld_f3, r_ld_off);
          w_rd         = r_ld_rd;
          w_wr         = r_ld_rd != 5'd0;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = WRITE;
          w_fire       = 1'b1;
          w_err        = 1'b1;
        end
      end
      WRITE:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Retire strobes are set on the edge entering WRITE and cleared on the edge leaving it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_ld_rd    <= '0;
      r_ld_f3    <= '0;
      r_ld_off   <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_write    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_write <= w_fire & w_wr;
      r_done  <= w_fire;
      r_err   <= w_fire & w_err;
      if (r_state == MEM_WAIT && w_next_state == MEM_WAIT) r_cnt <= r_cnt + CW'(1);
      else                                                 r_cnt <= '0;
      if (w_load_go) begin
        r_mem_addr <= {alu_result[31:2], 2'b00};
        r_ld_rd    <= w_rd_in;
        r_ld_f3    <= w_f3_in;
        r_ld_off   <= alu_result[1:0];
      end
      if (w_fire && w_wr) begin
        r_wdata <= w_wdata;
        r_rd    <= w_rd;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign mem_req   = (r_state == MEM_WAIT);
  assign mem_addr  = r_mem_addr;
  assign WriteData = r_wdata;
  assign wb_rd     = r_rd;
  assign Write     = r_write;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed plus random instruction stream against a reference model of the retire rules.
module tb_writeback_ctrl;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction, alu_result, pc, imm;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] WriteData;
  logic        Write;
  logic [4:0]  wb_rd;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  writeback_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .alu_result(alu_result), .pc(pc), .imm(imm),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .WriteData(WriteData), .Write(Write), .wb_rd(wb_rd), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int f3);
    logic [4:0] r;
    logic [2:0] f;
    r = 5'(rd);
    f = 3'(f3);
    return {17'd0, f, r, op};
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] d, input int f3, input int off);
    logic [31:0] b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (8 * off)) & 32'hFFFF;
    case (f3)
      0:       return (b >= 32'd128)   ? b - 32'd256   : b;
      1:       return (h >= 32'd32768) ? h - 32'd65536 : h;
      4:       return b;
      5:       return h;
      default: return d;
    endcase
  endfunction

  function automatic bit bad_align(input int f3, input int off);
    if (f3 == 0 || f3 == 4) return 1'b0;
    if (f3 == 1 || f3 == 5) return (off % 2) != 0;
    return off != 0;
  endfunction

  // dly: MEM_WAIT cycle (1-based) in which mem_rvalid is presented; outside 1..T means never.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] pcv,
                           input logic [31:0] immv, input int dly, input logic [31:0] rdata,
                           input string tag);
    bit          exp_wr, exp_err, seen;
    logic [31:0] exp_wd;
    int          exp_req, k, lat;
    exp_wr = 0; exp_err = 0; exp_wd = 0; exp_req = 0; k = 0; lat = 0; seen = 0;
    case (ins[6:0])
      7'b0110011, 7'b0010011: begin exp_wr = 1; exp_wd = alu; end
      7'b1101111, 7'b1100111: begin exp_wr = 1; exp_wd = pcv + 32'd4; end
      7'b0110111:             begin exp_wr = 1; exp_wd = immv; end
      7'b0010111:             begin exp_wr = 1; exp_wd = pcv + immv; end
      7'b0000011: begin
        if (bad_align(int'(ins[14:12]), int'(alu[1:0]))) exp_err = 1;
        else if (dly >= 1 && dly <= T) begin
          exp_req = dly; exp_wr = 1; exp_wd = load_val(rdata, int'(ins[14:12]), int'(alu[1:0]));
        end else begin
          exp_req = T; exp_err = 1;
        end
      end
      default: ;
    endcase
    if (ins[11:7] == 5'd0) exp_wr = 0;

    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; instruction = ins; alu_result = alu; pc = pcv; imm = immv;
    mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    for (int c = 1; c <= 3 * T + 8 && !seen; c++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      instruction = $urandom; alu_result = $urandom; pc = $urandom; imm = $urandom;
      if (done) begin
        seen = 1; lat = c;
        chk({tag, ".Write"}, 32'(Write), 32'(exp_wr));
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        chk({tag, ".ready_wr"}, 32'(in_ready), 32'd0);
        if (exp_wr) begin
          chk({tag, ".WriteData"}, WriteData, exp_wd);
          chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(ins[11:7]));
        end
        mem_rvalid = 1'($urandom_range(0, 1));
      end else begin
        chk({tag, ".busy"}, {29'd0, Write, err, in_ready}, 32'd0);
        if (mem_req) begin
          k++;
          chk({tag, ".mem_addr"}, mem_addr, {alu[31:2], 2'b00});
          mem_rvalid = (k == dly);
          mem_rdata  = (k == dly) ? rdata : $urandom;
        end else begin
          mem_rvalid = 1'($urandom_range(0, 1));
        end
      end
    end
    chk({tag, ".retired"}, 32'(seen), 32'd1);
    chk({tag, ".req_cycles"}, k, exp_req);
    chk({tag, ".latency"}, lat, exp_req + 1);
    @(negedge clk);
    in_valid = 1'b0; mem_rvalid = 1'b0;
    chk({tag, ".after"}, {29'd0, done, Write, err}, 32'd0);
    chk({tag, ".ready_after"}, 32'(in_ready), 32'd1);
  endtask

  logic [6:0] ops [12] = '{7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111,
                           7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011, 7'b0000011, 7'b1111111};

  initial begin
    logic [31:0] ins, alu;
    rst = 1'b1; in_valid = 1'b0; instruction = '0; alu_result = '0; pc = '0; imm = '0;
    mem_rdata = '0; mem_rvalid = 1'b0;
    #1;
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.strobes", {28'd0, mem_req, Write, done, err}, 32'd0);
    chk("rst.WriteData", WriteData, 32'd0);
    chk("rst.wb_rd", 32'(wb_rd), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_instr(mk(7'b0110011, 5, 0), 32'h7, 32'h40, 32'h0, 0, 32'h0, "add_x5");
    run_instr(mk(7'b1101111, 1, 0), 32'h0, 32'h100, 32'h20, 0, 32'h0, "jal_x1");
    run_instr(mk(7'b1101111, 0, 0), 32'h0, 32'h100, 32'h20, 0, 32'h0, "jal_x0");
    run_instr(mk(7'b0000011, 3, 0), 32'h203, 32'h0, 32'h0, 3, 32'h80FF_FF11, "lb_x3");
    run_instr(mk(7'b0000011, 7, 5), 32'h202, 32'h0, 32'h0, 2, 32'h8001_1234, "lhu");
    run_instr(mk(7'b0000011, 8, 2), 32'h201, 32'h0, 32'h0, 1, 32'h1234_5678, "lw_misal");
    run_instr(mk(7'b0000011, 9, 2), 32'h300, 32'h0, 32'h0, 0, 32'h0, "lw_timeout");
    run_instr(mk(7'b0010111, 10, 0), 32'h0, 32'hFFFF_FFF0, 32'h20, 0, 32'h0, "auipc_wrap");
    run_instr(mk(7'b0100011, 11, 2), 32'h44, 32'h0, 32'h0, 0, 32'h0, "store");

    // Reset in the middle of a load, then a late response that must be dropped.
    in_valid = 1'b1; instruction = mk(7'b0000011, 4, 2); alu_result = 32'h400;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst.req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst.strobes", {28'd0, mem_req, Write, done, err}, 32'd0);
    chk("midrst.WriteData", WriteData, 32'd0);
    chk("midrst.wb_rd", 32'(wb_rd), 32'd0);
    chk("midrst.mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    chk("midrst.ready_first", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst.late_rvalid", {28'd0, mem_req, Write, done, err}, 32'd0);
    end
    mem_rvalid = 1'b0;
    run_instr(mk(7'b0110011, 5, 0), 32'h7, 32'h0, 32'h0, 0, 32'h0, "add_after_rst");

    for (int n = 0; n < 150; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      alu = $urandom;
      run_instr(ins, alu, $urandom, $urandom, int'($urandom_range(0, T + 1)), $urandom, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
